// File: rtl/uart_telemetry_arbiter_pkg.sv
// Shared types and constants for the UART telemetry arbiter.
package telemetry_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  typedef enum logic {
    PKT_PITCH  = 1'b0,
    PKT_SAMPLE = 1'b1
  } pkt_t;

  localparam int unsigned PKT_LEN        = 3;
  localparam int unsigned ACK_TIMEOUT    = 4;
  localparam logic [7:0]  HDR_SAMPLE_DEF = 8'h5A;
  localparam logic [7:0]  HDR_PITCH_DEF  = 8'hA5;

  // Byte idx of a packet: header, then shadow high byte, then shadow low byte.
  function automatic logic [7:0] pkt_byte(input pkt_t       t,
                                          input logic [1:0] idx,
                                          input logic [15:0] shadow,
                                          input logic [7:0] hdr_pitch,
                                          input logic [7:0] hdr_sample);
    logic [7:0] b;
    case (idx)
      2'd0:    b = (t == PKT_PITCH) ? hdr_pitch : hdr_sample;
      2'd1:    b = shadow[15:8];
      default: b = shadow[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_telemetry_arbiter_if.sv
// Byte/trigger/busy handshake between the arbiter and uart_transmit.
interface uart_telemetry_arbiter_if;
  logic [7:0] data_byte_out;
  logic       trigger_out;
  logic       uart_busy_in;

  modport master (output data_byte_out, output trigger_out, input uart_busy_in);
  modport slave  (input data_byte_out, input trigger_out, output uart_busy_in);
endinterface

// File: rtl/uart_telemetry_arbiter_slot.sv
// One-deep pending holder: latest capture wins, overwriting a full slot
// without a same-cycle drain raises a drop strobe.
module telemetry_pending_slot #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             i_capture,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_drain,
  output logic             o_full,
  output logic [WIDTH-1:0] o_data,
  output logic             o_drop
);

  logic             r_full;
  logic [WIDTH-1:0] r_data;

  // Capture takes precedence over drain so a same-cycle refill keeps the slot full.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_capture) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end else if (i_drain) begin
      r_full <= 1'b0;
    end
  end

  assign o_full = r_full;
  assign o_data = r_data;
  assign o_drop = i_capture && r_full && !i_drain;

endmodule

// File: rtl/uart_telemetry_arbiter.sv
// Shares one uart_transmit between decimated mic samples and yin pitch
// results, framing each item as a 3-byte packet; pitch has priority.
module uart_telemetry_arbiter
  import telemetry_pkg::*;
#(
  parameter int unsigned SAMPLE_DECIM = 64,
  parameter logic [7:0]  HDR_SAMPLE   = HDR_SAMPLE_DEF,
  parameter logic [7:0]  HDR_PITCH    = HDR_PITCH_DEF
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        enable_in,
  input  logic [15:0] sample_in,
  input  logic        sample_valid_in,
  input  logic [10:0] taumin_in,
  input  logic        taumin_valid_in,
  uart_telemetry_arbiter_if.master uart,
  output logic [7:0]  drop_count_out
);

  localparam logic [15:0] DECIM_LAST = 16'(SAMPLE_DECIM - 1);
  localparam logic [1:0]  IDX_LAST   = 2'(PKT_LEN - 1);
  localparam logic [1:0]  ACK_LAST   = 2'(ACK_TIMEOUT - 1);

  logic [15:0] r_decim;
  logic [7:0]  r_drop;
  state_t      r_state, w_state_nx;
  pkt_t        r_type, w_type_nx;
  logic [1:0]  r_idx, w_idx_nx;
  logic [1:0]  r_ack_cnt, w_ack_cnt_nx;
  logic [15:0] r_shadow, w_shadow_nx;
  logic [7:0]  r_byte, w_byte_nx;
  logic        r_trig, w_trig_nx;

  logic        w_decim_hit, w_cap_s, w_cap_p;
  logic        w_drain_s, w_drain_p;
  logic        w_full_s, w_full_p;
  logic        w_drop_s, w_drop_p;
  logic [15:0] w_data_s;
  logic [10:0] w_data_p;
  logic [8:0]  w_drop_sum;

  assign w_decim_hit = sample_valid_in && (r_decim == DECIM_LAST);
  assign w_cap_s     = w_decim_hit && enable_in;
  assign w_cap_p     = taumin_valid_in && enable_in;

  // Decimation counter runs on every valid sample regardless of enable.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_decim <= '0;
    end else if (sample_valid_in) begin
      r_decim <= w_decim_hit ? '0 : r_decim + 16'd1;
    end
  end

  telemetry_pending_slot #(.WIDTH(16)) u_slot_s (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .i_capture (w_cap_s),
    .i_data    (sample_in),
    .i_drain   (w_drain_s),
    .o_full    (w_full_s),
    .o_data    (w_data_s),
    .o_drop    (w_drop_s)
  );

  telemetry_pending_slot #(.WIDTH(11)) u_slot_p (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .i_capture (w_cap_p),
    .i_data    (taumin_in),
    .i_drain   (w_drain_p),
    .o_full    (w_full_p),
    .o_data    (w_data_p),
    .o_drop    (w_drop_p)
  );

  assign w_drop_sum = {1'b0, r_drop} + {8'd0, w_drop_s} + {8'd0, w_drop_p};

  // Saturating drop counter; both slots may drop in the same cycle.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_drop <= '0;
    end else begin
      r_drop <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end
  end

  // FSM and datapath registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state   <= IDLE;
      r_type    <= PKT_PITCH;
      r_idx     <= '0;
      r_ack_cnt <= '0;
      r_shadow  <= '0;
      r_byte    <= '0;
      r_trig    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_type    <= w_type_nx;
      r_idx     <= w_idx_nx;
      r_ack_cnt <= w_ack_cnt_nx;
      r_shadow  <= w_shadow_nx;
      r_byte    <= w_byte_nx;
      r_trig    <= w_trig_nx;
    end
  end

  // Next-state: arbitrate in IDLE only, then sequence bytes through the UART handshake.
  always_comb begin
    w_state_nx   = r_state;
    w_type_nx    = r_type;
    w_idx_nx     = r_idx;
    w_ack_cnt_nx = r_ack_cnt;
    w_shadow_nx  = r_shadow;
    w_byte_nx    = r_byte;
    w_trig_nx    = 1'b0;
    w_drain_s    = 1'b0;
    w_drain_p    = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable_in && (w_full_p || w_full_s)) begin
          if (w_full_p) begin
            w_drain_p   = 1'b1;
            w_type_nx   = PKT_PITCH;
            w_shadow_nx = {5'b0, w_data_p};
          end else begin
            w_drain_s   = 1'b1;
            w_type_nx   = PKT_SAMPLE;
            w_shadow_nx = w_data_s;
          end
          w_idx_nx   = '0;
          w_state_nx = SEND;
        end
      end
      SEND: begin
        if (!uart.uart_busy_in) begin
          w_byte_nx    = pkt_byte(r_type, r_idx, r_shadow, HDR_PITCH, HDR_SAMPLE);
          w_trig_nx    = 1'b1;
          w_ack_cnt_nx = '0;
          w_state_nx   = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (uart.uart_busy_in || (r_ack_cnt == ACK_LAST)) begin
          w_state_nx = WAIT_DONE;
        end else begin
          w_ack_cnt_nx = r_ack_cnt + 2'd1;
        end
      end
      WAIT_DONE: begin
        if (!uart.uart_busy_in) begin
          if (r_idx == IDX_LAST) begin
            w_state_nx = IDLE;
          end else begin
            w_idx_nx   = r_idx + 2'd1;
            w_state_nx = SEND;
          end
        end
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign uart.data_byte_out = r_byte;
  assign uart.trigger_out   = r_trig;
  assign drop_count_out     = r_drop;

endmodule

// File: tb/tb_uart_telemetry_arbiter.sv
// Scoreboard bench: stimulus pushes expected UART bytes, a monitor pops and
// compares on every trigger_out pulse.
module tb_uart_telemetry_arbiter;
  import telemetry_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic [15:0] sample = '0;
  logic        sample_valid = 1'b0;
  logic [10:0] taumin = '0;
  logic        taumin_valid = 1'b0;
  logic [7:0]  drop_count;

  logic        hold_busy = 1'b0;
  logic        never_busy = 1'b0;
  int unsigned busy_len = 10;
  int unsigned busy_cnt = 0;

  int n_checks = 0;
  int n_fail = 0;
  int trig_count = 0;
  logic [7:0] exp_q[$];

  uart_telemetry_arbiter_if uif();

  uart_telemetry_arbiter #(
    .SAMPLE_DECIM (4),
    .HDR_SAMPLE   (8'h5A),
    .HDR_PITCH    (8'hA5)
  ) dut (
    .clk_in          (clk),
    .rst_in          (rst_n),
    .enable_in       (enable),
    .sample_in       (sample),
    .sample_valid_in (sample_valid),
    .taumin_in       (taumin),
    .taumin_valid_in (taumin_valid),
    .uart            (uif.master),
    .drop_count_out  (drop_count)
  );

  always #5 clk = ~clk;

  // UART model: busy for busy_len cycles after each trigger.
  always @(posedge clk) begin
    if (uif.trigger_out && !never_busy) busy_cnt <= busy_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign uif.uart_busy_in = hold_busy || (busy_cnt != 0);

  // Monitor: every trigger must match the next expected byte.
  always @(negedge clk) begin
    if (rst_n && uif.trigger_out) begin
      trig_count++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_trigger: got byte %02h, none expected", uif.data_byte_out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (uif.data_byte_out !== e) begin
          n_fail++;
          $display("FAIL uart_byte: got %02h expected %02h", uif.data_byte_out, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
  endtask

  // One-cycle strobe(s); called and returns at posedge+1.
  task automatic pulse(input bit s, input bit t, input logic [15:0] sv, input logic [10:0] tv);
    sample = sv;
    taumin = tv;
    sample_valid = s;
    taumin_valid = t;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    taumin_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: %0d bytes still pending, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int t0;
    int unsigned n;
    #1;
    idle(3);
    check("reset_trigger", 32'(uif.trigger_out), 32'd0);
    check("reset_data", 32'(uif.data_byte_out), 32'd0);
    check("reset_drop", 32'(drop_count), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Decimation by 4, latency and byte hold.
    t0 = trig_count;
    push3(8'h5A, 8'h12, 8'h34);
    pulse(1, 0, 16'h1111, '0);
    pulse(1, 0, 16'h2222, '0);
    pulse(1, 0, 16'h3333, '0);
    pulse(1, 0, 16'h1234, '0);
    @(negedge clk);
    check("latency_c0", 32'(uif.trigger_out), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("latency_c1", 32'(uif.trigger_out), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("latency_c2", 32'(uif.trigger_out), 32'd1);
    @(posedge clk);
    #1;
    drain("decim");
    check("decim_triggers", 32'(trig_count - t0), 32'd3);
    check("decim_drop", 32'(drop_count), 32'd0);
    check("byte_hold", 32'(uif.data_byte_out), 32'h34);

    // Simultaneous capture: pitch first.
    push3(8'hA5, 8'h05, 8'hC3);
    push3(8'h5A, 8'hBE, 8'hEF);
    pulse(1, 0, 16'h0001, '0);
    pulse(1, 0, 16'h0002, '0);
    pulse(1, 0, 16'h0003, '0);
    pulse(1, 1, 16'hBEEF, 11'h5C3);
    drain("simul");

    // Pitch arriving mid sample packet waits.
    push3(8'h5A, 8'hCA, 8'hFE);
    push3(8'hA5, 8'h00, 8'h10);
    pulse(1, 0, 16'h0000, '0);
    pulse(1, 0, 16'h0000, '0);
    pulse(1, 0, 16'h0000, '0);
    pulse(1, 0, 16'hCAFE, '0);
    idle(6);
    pulse(0, 1, '0, 11'h010);
    drain("no_preempt");

    // Overwrites while the UART is held busy.
    hold_busy = 1'b1;
    push3(8'h5A, 8'h0F, 8'h0F);
    push3(8'hA5, 8'h00, 8'h03);
    pulse(1, 0, 16'h0000, '0);
    pulse(1, 0, 16'h0000, '0);
    pulse(1, 0, 16'h0000, '0);
    pulse(1, 0, 16'h0F0F, '0);
    idle(4);
    pulse(0, 1, '0, 11'h001);
    pulse(0, 1, '0, 11'h002);
    pulse(0, 1, '0, 11'h003);
    idle(1);
    check("drop_two", 32'(drop_count), 32'd2);
    hold_busy = 1'b0;
    drain("overwrite");

    hold_busy = 1'b1;
    push3(8'hA5, 8'h01, 8'h00);
    push3(8'hA5, 8'h07, 8'hFF);
    pulse(0, 1, '0, 11'h100);
    idle(4);
    for (int i = 0; i < 300; i++) pulse(0, 1, '0, 11'(i));
    pulse(0, 1, '0, 11'h7FF);
    idle(1);
    check("drop_saturate", 32'(drop_count), 32'd255);
    hold_busy = 1'b0;
    drain("saturate");
    check("drop_hold_sat", 32'(drop_count), 32'd255);

    // Asynchronous reset during the second byte.
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h02);
    pulse(0, 1, '0, 11'h2AB);
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      if (uif.trigger_out && uif.data_byte_out == 8'h02) break;
      n++;
    end
    check("second_byte_seen", 32'(n < 300), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_trigger", 32'(uif.trigger_out), 32'd0);
    check("rst_data", 32'(uif.data_byte_out), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    check("rst_state", 32'(dut.r_state), 32'(IDLE));
    check("rst_full_p", 32'(dut.u_slot_p.r_full), 32'd0);
    check("rst_full_s", 32'(dut.u_slot_s.r_full), 32'd0);
    check("rst_decim", 32'(dut.r_decim), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drain("after_reset");

    // enable low: in-flight packet completes, slots retained, no capture.
    hold_busy = 1'b1;
    push3(8'hA5, 8'h01, 8'h11);
    push3(8'h5A, 8'h43, 8'h21);
    pulse(0, 1, '0, 11'h111);
    idle(3);
    pulse(1, 0, 16'h0000, '0);
    pulse(1, 0, 16'h0000, '0);
    pulse(1, 0, 16'h0000, '0);
    pulse(1, 0, 16'h4321, '0);
    enable = 1'b0;
    hold_busy = 1'b0;
    n = 0;
    while (exp_q.size() != 3 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    for (int i = 0; i < 10; i++) pulse(0, 1, '0, 11'(i + 40));
    idle(40);
    check("disabled_pending", 32'(exp_q.size()), 32'd3);
    check("disabled_drop", 32'(drop_count), 32'd0);
    enable = 1'b1;
    drain("reenable");

    // Transmitter that never reports busy: WAIT_ACK timeout.
    never_busy = 1'b1;
    push3(8'hA5, 8'h07, 8'hA5);
    pulse(0, 1, '0, 11'h7A5);
    drain("ack_timeout");
    never_busy = 1'b0;
    check("final_drop", 32'(drop_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/uart_telemetry_arbiter.md
Name: uart_telemetry_arbiter

Overview:
- Shares the single uart_transmit instance between two producers: decimated microphone samples from i2s_receiver and pitch results (taumin) from yin.
- Frames each item as a 3-byte packet and sequences bytes into the UART via its trigger/busy handshake.
- Pitch packets have strict priority over sample packets; a packet is never interrupted once started.
- Sits in top_level between i2s_receiver/yin and uart_transmit; replaces the direct raw_mic_debug_data hookup.

Parameters:
- SAMPLE_DECIM, 64, forward one of every SAMPLE_DECIM valid samples (1 = every sample); range 1..65535.
- HDR_SAMPLE, 8'h5A, header byte of a sample packet.
- HDR_PITCH, 8'hA5, header byte of a pitch packet.

Ports:
- clk_in  input  1  system clock, 100 MHz.
- rst_in  input  1  asynchronous, active-low reset.
- enable_in  input  1  when low, no new packets start; a packet in flight completes.
- sample_in  input  16  signed mic sample.
- sample_valid_in  input  1  one-cycle strobe qualifying sample_in.
- taumin_in  input  11  pitch period from yin.
- taumin_valid_in  input  1  one-cycle strobe qualifying taumin_in.
- uart_busy_in  input  1  busy_out of uart_transmit.
- data_byte_out  output  8  byte to uart_transmit.
- trigger_out  output  1  one-cycle pulse launching data_byte_out.
- drop_count_out  output  8  saturating count of overwritten pending items (both sources).

Behaviour:
- Reset (rst_in low, asynchronous): state IDLE, data_byte_out=0, trigger_out=0, drop_count_out=0, both pending flags clear, decimation counter=0.
- Decimation: counter increments on each sample_valid_in. When it reaches SAMPLE_DECIM-1, it wraps to 0 and the sample is captured into a 16-bit pending slot.
- Capture is gated by enable_in. When enable_in is low, the counter still runs but nothing is captured.
- taumin_valid_in with enable_in high captures into an 11-bit pending slot.
- Overwrite rule: a capture into an already-full slot replaces the old value (latest wins) and increments drop_count_out, saturating at 255.
  - Capture and drain in the same cycle on the same slot is not a drop; the slot stays full with the new value.
  - If both slots drop in the same cycle, drop_count_out increments by 2 (still saturating).
- Packet formats:
  - pitch: HDR_PITCH, {5'b0, taumin[10:8]}, taumin[7:0].
  - sample: HDR_SAMPLE, sample[15:8], sample[7:0].
- Packet payload is latched into a 16-bit shadow register and a type bit when the packet starts; the pending slot clears that cycle.
- State machine:
  - IDLE: if enable_in is high and either slot is full, select pitch if its slot is full, else sample. Latch the shadow, set byte index=0, go to SEND.
  - SEND: if uart_busy_in is low, drive data_byte_out = byte[index], pulse trigger_out for one cycle, go to WAIT_ACK. Otherwise stay in SEND.
  - WAIT_ACK: wait for uart_busy_in high, then go to WAIT_DONE. If busy is not seen within 4 cycles, go to WAIT_DONE anyway (tolerates a transmitter that finishes instantly).
  - WAIT_DONE: wait for uart_busy_in low. Then, if index==2, go to IDLE; else increment index and go to SEND.
- Latency: with the UART idle, the header trigger asserts 2 cycles after the capture strobe (capture edge, IDLE→SEND edge, trigger in SEND).
- data_byte_out holds its value from trigger until the next trigger.
- Priority is evaluated only in IDLE. A pitch result arriving mid-sample-packet waits until that packet ends.
- Simultaneous captures of both sources in one cycle: both are accepted; pitch is sent first.
- enable_in falling mid-packet: the packet completes, then the block idles with its slots retained. Slots resume draining when enable_in rises.
- Reset mid-packet: the packet is abandoned immediately and trigger_out drops. The host resynchronises on header bytes.

Decomposition:
- Package telemetry_pkg:
  - state enum {IDLE, SEND, WAIT_ACK, WAIT_DONE}.
  - packet-type enum {PKT_PITCH, PKT_SAMPLE}.
  - PKT_LEN=3.
  - default header constants.
- One sub-module, telemetry_pending_slot: a parameterised-width holding register with full flag, overwrite and drop strobe. It is instantiated twice, for widths 16 and 11.
- Arbitration, framing and FSM stay in the top module.

Test Plan:
- SAMPLE_DECIM=4, four sample strobes, last value 16'h1234, UART model busy for 10 cycles after each trigger → bytes 5A,12,34 emitted, three triggers, drop_count_out=0.
- taumin 11'h5C3 and a decimated sample 16'hBEEF captured in the same cycle → bytes A5,05,C3 then 5A,BE,EF.
- Sample packet in flight, then taumin 11'h010 strobe → sample packet completes unbroken, then A5,00,10.
- UART held busy; three taumin strobes 11'h001, 11'h002, 11'h003 → one packet A5,00,03, drop_count_out=2. Then 300 further overwrites → drop_count_out saturates at 255.
- rst_in pulsed low during the second byte → trigger_out=0, data_byte_out=0, state IDLE, slots empty, all asynchronously before the next clock edge.
- enable_in low with 10 pitch strobes → no trigger_out, no drops counted. Then enable_in high with a pending sample → sample packet sent. WAIT_ACK timeout checked with a UART model that never asserts busy.
